branch_predict_resolve: RTL and testbench
=========================================

Name: branch_predict_resolve

Overview:
- Next-generation branch unit. Replaces the purely combinational taken/not-taken decision with a parametrised prediction and resolution unit.
- IF side: a direct-mapped Branch History Table (BHT) of 2-bit saturating counters plus a tagged Branch Target Buffer (BTB) give a predicted direction and target each cycle.
- EX side: resolves all conditional branches, jal and jalr from ALU flags, detects mispredictions, drives the flush/redirect, and trains the tables.
- Also keeps wrap-around branch and mispredict statistics counters.

Parameters:
- XLEN, 32, PC/target width.
- IDX_W, 6, log2 of BHT/BTB entries (64 entries); index = pc[IDX_W+1:2].
- TAG_W, 8, BTB tag width; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; IDX_W+TAG_W+2 <= XLEN.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- if_pc  in  XLEN  fetch PC.
- if_valid  in  1  fetch slot valid.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted target; if_pc+4 when pred_taken=0.
- ex_valid  in  1  EX holds a valid instruction.
- ex_hold  in  1  EX stalled; no training, no stats, no redirect.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_br_type  in  4  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jal, 8 jalr; 9-15 treated as none.
- ex_zero  in  1  ALU result zero (rs1==rs2).
- ex_lt  in  1  signed rs1<rs2.
- ex_ltu  in  1  unsigned rs1<rs2.
- ex_target  in  XLEN  computed taken target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- ex_taken  out  1  resolved direction.
- mispredict  out  1  flush IF/ID and redirect.
- redirect_pc  out  XLEN  correct next PC when mispredict=1.
- stat_branches  out  CNT_W  resolved control-transfer count.
- stat_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n low). On reset:
  - all BHT counters = 2'b01 (weakly not-taken);
  - all BTB valid bits = 0;
  - both stat counters = 0.
  - Reset mid-operation drops any pending update.
- Prediction (combinational from if_pc and current table state):
  - hit = BTB valid && tag match.
  - pred_taken = if_valid && hit && BHT[idx][1].
  - pred_target = BTB target on pred_taken, otherwise if_pc+4.
  - Outputs are 0 / if_pc+4 when if_valid=0.
- Resolution (combinational):
  - ex_taken = jal | jalr | beq&zero | bne&!zero | blt&lt | bge&!lt | bltu&ltu | bgeu&!ltu.
  - ex_taken is gated by ex_valid and a legal branch type.
- Mispredict:
  - mispredict = resolve_en && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
  - resolve_en = ex_valid && !ex_hold && type in 1..8.
  - redirect_pc = ex_target if ex_taken, else ex_pc+4.
  - When mispredict=0, redirect_pc = ex_pc+4 (don't-care to consumers).
- Training (posedge clk, when resolve_en):
  - BHT[ex idx]: saturating +1 if taken, -1 if not; stays at 3 / 0.
  - jal/jalr train BHT toward taken like conditionals.
  - If taken: BTB[ex idx] <= {valid=1, ex tag, ex_target}; overwrites any alias.
  - Not-taken never invalidates the BTB.
- Statistics (posedge clk): stat_branches +1 on resolve_en; stat_mispredicts +1 on mispredict. Both wrap at 2^CNT_W.
- Same-cycle read and write to the same index: prediction sees the OLD entry (no bypass). The write is visible from the next cycle.
- Latency:
  - prediction and resolution are 0 cycles (combinational);
  - table and stat updates are visible 1 cycle after the resolving edge.
- ex_hold=1 with a valid branch: nothing changes and mispredict=0. The branch resolves once ex_hold drops.

Decomposition:
- Shared package branch_pkg:
  - BR_NONE..BR_JALR encodings (4-bit);
  - 2-bit counter constants SNT=0, WNT=1, WT=2, ST=3;
  - index/tag slice helper widths.
- One natural sub-module, bp_table: BHT+BTB storage with one combinational read port, one synchronous write port and async reset. The top keeps resolution, mispredict and stats.

Test Plan:
1. Reset then if_pc=0x100, if_valid=1 -> pred_taken=0, pred_target=0x104; stats=0.
2. beq at ex_pc=0x100, ex_zero=1, ex_target=0x80, ex_pred_taken=0 -> ex_taken=1, mispredict=1, redirect_pc=0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80 (counter 01->10).
3. Same branch resolved taken 3 more times, then not-taken -> counter saturates at 3, then 2; pred_taken stays 1. stat_branches=5, stat_mispredicts=2 (first train plus the final not-taken).
4. jalr with predicted target 0x200, actual ex_target 0x300 -> mispredict=1, redirect_pc=0x300; BTB target becomes 0x300.
5. Two PCs aliasing the same index with different tags -> second taken branch evicts the first; first PC then predicts not-taken (pred_target=pc+4).
6. ex_hold=1 on a mispredicting bltu (ex_ltu=1) for 3 cycles -> mispredict=0 and stats unchanged. On release: mispredict=1 for one cycle and stats +1. Assert rst_n=0 mid-sequence -> tables and stats cleared immediately.

Source files
------------

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared encodings and helpers for the branch prediction and
//                resolution unit: control-transfer type codes, 2-bit
//                saturating counter states and the PC slicing offset.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Control-transfer type codes as presented on ex_br_type.
    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JALR = 4'd8;

    // 2-bit saturating direction counter states.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Instructions are word aligned, so table index starts at pc[2].
    localparam int PC_ALIGN_LSB = 2;

    // Types 1..8 are control transfers; everything else behaves as none.
    function automatic logic br_legal(input logic [3:0] br_type);
        return (br_type >= BR_BEQ) && (br_type <= BR_JALR);
    endfunction

    // Saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != ST)
            nxt = ctr + 2'd1;
        else if (!taken && ctr != SNT)
            nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
// ============================================================================
//  Module      : bp_table
//  Description : Direct-mapped BHT (2-bit counters) plus tagged BTB storage.
//                One combinational read port (prediction) and one synchronous
//                write port (training). Reads see the pre-edge contents, so a
//                same-cycle write to the read index is not bypassed.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                rd_idx/rd_tag       - lookup index and tag
//                rd_hit/rd_ctr/rd_target - BTB hit, counter, stored target
//                wr_en/wr_idx/wr_tag/wr_taken/wr_target - training port
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_table
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [1:0]       rd_ctr,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_taken,
    input  logic [XLEN-1:0]  wr_target
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [1:0]       r_bht    [c_DEPTH];
    logic             r_valid  [c_DEPTH];
    logic [TAG_W-1:0] r_tag    [c_DEPTH];
    logic [XLEN-1:0]  r_target [c_DEPTH];

    // Counters and valid bits need reset; tag/target are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_bht[i]   <= WNT;
                r_valid[i] <= 1'b0;
            end
        end else if (wr_en) begin
            r_bht[wr_idx] <= ctr_next(r_bht[wr_idx], wr_taken);
            // Not-taken outcomes never invalidate an entry.
            if (wr_taken)
                r_valid[wr_idx] <= 1'b1;
        end
    end

    // Taken outcomes overwrite whatever alias held this slot.
    always_ff @(posedge clk) begin
        if (wr_en && wr_taken) begin
            r_tag[wr_idx]    <= wr_tag;
            r_target[wr_idx] <= wr_target;
        end
    end

    always_comb begin
        rd_hit    = r_valid[rd_idx] && (r_tag[rd_idx] == rd_tag);
        rd_ctr    = r_bht[rd_idx];
        rd_target = r_target[rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_resolve
//  Description : Branch prediction (IF) and resolution (EX) unit. Predicts
//                direction/target from the BHT/BTB, resolves branches and
//                jumps from ALU flags, flags mispredictions with a redirect
//                PC, trains the tables and keeps wrap-around statistics.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                if_pc, if_valid            - fetch slot
//                pred_taken, pred_target    - prediction
//                ex_valid, ex_hold, ex_pc, ex_br_type, ex_zero, ex_lt,
//                ex_ltu, ex_target, ex_pred_taken, ex_pred_target - EX slot
//                ex_taken, mispredict, redirect_pc - resolution
//                stat_branches, stat_mispredicts   - statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_valid,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_hold,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [3:0]       ex_br_type,
    input  logic             ex_zero,
    input  logic             ex_lt,
    input  logic             ex_ltu,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             ex_taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int c_IDX_LSB = PC_ALIGN_LSB;
    localparam int c_TAG_LSB = PC_ALIGN_LSB + IDX_W;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_rd_hit;
    logic [1:0]       w_rd_ctr;
    logic [XLEN-1:0]  w_rd_target;
    logic             w_legal;
    logic             w_dir;
    logic             w_resolve_en;
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;

    assign w_if_idx = if_pc[c_IDX_LSB +: IDX_W];
    assign w_if_tag = if_pc[c_TAG_LSB +: TAG_W];
    assign w_ex_idx = ex_pc[c_IDX_LSB +: IDX_W];
    assign w_ex_tag = ex_pc[c_TAG_LSB +: TAG_W];

    bp_table #(
        .XLEN  (XLEN),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (w_if_idx),
        .rd_tag    (w_if_tag),
        .rd_hit    (w_rd_hit),
        .rd_ctr    (w_rd_ctr),
        .rd_target (w_rd_target),
        .wr_en     (w_resolve_en),
        .wr_idx    (w_ex_idx),
        .wr_tag    (w_ex_tag),
        .wr_taken  (ex_taken),
        .wr_target (ex_target)
    );

    // Prediction: counter MSB decides direction, but only on a BTB hit.
    always_comb begin
        pred_taken  = if_valid && w_rd_hit && w_rd_ctr[1];
        pred_target = pred_taken ? w_rd_target : (if_pc + XLEN'(4));
    end

    // Resolution from ALU flags.
    always_comb begin
        w_dir = 1'b0;
        case (ex_br_type)
            BR_BEQ:  w_dir = ex_zero;
            BR_BNE:  w_dir = !ex_zero;
            BR_BLT:  w_dir = ex_lt;
            BR_BGE:  w_dir = !ex_lt;
            BR_BLTU: w_dir = ex_ltu;
            BR_BGEU: w_dir = !ex_ltu;
            BR_JAL:  w_dir = 1'b1;
            BR_JALR: w_dir = 1'b1;
            default: w_dir = 1'b0;
        endcase
    end

    assign w_legal      = br_legal(ex_br_type);
    assign w_resolve_en = ex_valid && !ex_hold && w_legal;

    // A held instruction still reports its direction; it just cannot act.
    always_comb begin
        ex_taken    = ex_valid && w_legal && w_dir;
        mispredict  = w_resolve_en &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = (mispredict && ex_taken) ? ex_target : (ex_pc + XLEN'(4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_resolve_en)
                r_stat_branches <= r_stat_branches + CNT_W'(1);
            if (mispredict)
                r_stat_mispredicts <= r_stat_mispredicts + CNT_W'(1);
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_resolve
//  Description : Directed-vector bench. Each driven cycle pushes a hand
//                computed expectation; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;
    import branch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_hold;
    logic [31:0] ex_pc;
    logic [3:0]  ex_br_type;
    logic        ex_zero;
    logic        ex_lt;
    logic        ex_ltu;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predict_resolve #(
        .XLEN (32), .IDX_W (6), .TAG_W (8), .CNT_W (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_valid         (if_valid),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_hold          (ex_hold),
        .ex_pc            (ex_pc),
        .ex_br_type       (ex_br_type),
        .ex_zero          (ex_zero),
        .ex_lt            (ex_lt),
        .ex_ltu           (ex_ltu),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_taken         (ex_taken),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_p;
        bit          pt;
        logic [31:0] ptgt;
        bit          chk_e;
        bit          et;
        bit          mp;
        logic [31:0] rpc;
        bit          chk_s;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=0x%08h expected=0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk_p) begin
                cmp(e.name, "pred_taken",  32'(pred_taken), 32'(e.pt));
                cmp(e.name, "pred_target", pred_target, e.ptgt);
            end
            if (e.chk_e) begin
                cmp(e.name, "ex_taken",    32'(ex_taken), 32'(e.et));
                cmp(e.name, "mispredict",  32'(mispredict), 32'(e.mp));
                cmp(e.name, "redirect_pc", redirect_pc, e.rpc);
            end
            if (e.chk_s) begin
                cmp(e.name, "stat_branches",    stat_branches, e.sb);
                cmp(e.name, "stat_mispredicts", stat_mispredicts, e.sm);
            end
        end
    end

    task automatic drive_if(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
    endtask

    task automatic drive_ex(input logic v, input logic hold, input logic [3:0] t,
                            input logic [31:0] pc, input logic z, input logic lt,
                            input logic ltu, input logic [31:0] tgt,
                            input logic ppt, input logic [31:0] pptgt);
        ex_valid       = v;
        ex_hold        = hold;
        ex_br_type     = t;
        ex_pc          = pc;
        ex_zero        = z;
        ex_lt          = lt;
        ex_ltu         = ltu;
        ex_target      = tgt;
        ex_pred_taken  = ppt;
        ex_pred_target = pptgt;
    endtask

    task automatic ex_idle();
        drive_ex(1'b0, 1'b0, BR_NONE, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic push(input string name,
                        input bit chk_p, input bit pt, input logic [31:0] ptgt,
                        input bit chk_e, input bit et, input bit mp, input logic [31:0] rpc,
                        input bit chk_s, input logic [31:0] sbv, input logic [31:0] smv);
        exp_t e;
        e.name = name; e.chk_p = chk_p; e.pt = pt; e.ptgt = ptgt;
        e.chk_e = chk_e; e.et = et; e.mp = mp; e.rpc = rpc;
        e.chk_s = chk_s; e.sb = sbv; e.sm = smv;
        sb_q.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Direction table exercised under hold so the tables stay untouched.
    typedef struct {
        string       name;
        logic        v;
        logic [3:0]  t;
        logic        z;
        logic        lt;
        logic        ltu;
        bit          et;
    } dir_t;

    dir_t dirs[7];

    initial begin
        dirs[0] = '{"dir_blt_lt",    1'b1, BR_BLT,  1'b0, 1'b1, 1'b0, 1'b1};
        dirs[1] = '{"dir_bge_lt",    1'b1, BR_BGE,  1'b0, 1'b1, 1'b0, 1'b0};
        dirs[2] = '{"dir_bgeu_nltu", 1'b1, BR_BGEU, 1'b0, 1'b0, 1'b0, 1'b1};
        dirs[3] = '{"dir_bne_zero",  1'b1, BR_BNE,  1'b1, 1'b0, 1'b0, 1'b0};
        dirs[4] = '{"dir_type9",     1'b1, 4'd9,    1'b1, 1'b1, 1'b1, 1'b0};
        dirs[5] = '{"dir_jal",       1'b1, BR_JAL,  1'b0, 1'b0, 1'b0, 1'b1};
        dirs[6] = '{"dir_jal_inval", 1'b0, BR_JAL,  1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive_if(1'b0, 32'h0);
        ex_idle();
        repeat (2) @(posedge clk);
        #1;
        push("in_reset", 0, 0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
        next_cyc();
        rst_n = 1'b1;

        // 1: cold prediction
        drive_if(1'b1, 32'h100);
        push("cold_pred", 1, 0, 32'h104, 1, 0, 0, 32'h4, 1, 32'd0, 32'd0);
        next_cyc();

        // 2: beq taken, predicted not-taken; same-cycle read sees old entry
        drive_ex(1, 0, BR_BEQ, 32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
        push("beq_first", 1, 0, 32'h104, 1, 1, 1, 32'h80, 1, 32'd0, 32'd0);
        next_cyc();

        // 3: three more taken resolutions (correctly predicted), then not-taken
        drive_ex(1, 0, BR_BEQ, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        push("beq_t2", 1, 1, 32'h80, 1, 1, 0, 32'h104, 1, 32'd1, 32'd1);
        next_cyc();
        push("beq_t3", 1, 1, 32'h80, 1, 1, 0, 32'h104, 1, 32'd2, 32'd1);
        next_cyc();
        push("beq_t4", 1, 1, 32'h80, 1, 1, 0, 32'h104, 1, 32'd3, 32'd1);
        next_cyc();
        drive_ex(1, 0, BR_BEQ, 32'h100, 0, 0, 0, 32'h80, 1, 32'h80);
        push("beq_nt", 1, 1, 32'h80, 1, 0, 1, 32'h104, 1, 32'd4, 32'd1);
        next_cyc();
        ex_idle();
        push("after_sat", 1, 1, 32'h80, 1, 0, 0, 32'h4, 1, 32'd5, 32'd2);
        next_cyc();

        // 4: jalr with wrong predicted target
        drive_if(1'b1, 32'h204);
        drive_ex(1, 0, BR_JALR, 32'h204, 0, 0, 0, 32'h300, 1, 32'h200);
        push("jalr_tgt", 1, 0, 32'h208, 1, 1, 1, 32'h300, 1, 32'd5, 32'd2);
        next_cyc();
        ex_idle();
        push("jalr_btb", 1, 1, 32'h300, 0, 0, 0, 0, 1, 32'd6, 32'd3);
        next_cyc();

        // 5: alias on index 0 with a different tag evicts 0x100
        drive_if(1'b1, 32'h100);
        drive_ex(1, 0, BR_BNE, 32'h1100, 0, 0, 0, 32'h900, 0, 32'h1104);
        push("alias_bne", 1, 1, 32'h80, 1, 1, 1, 32'h900, 1, 32'd6, 32'd3);
        next_cyc();
        ex_idle();
        push("alias_old", 1, 0, 32'h104, 0, 0, 0, 0, 1, 32'd7, 32'd4);
        next_cyc();
        drive_if(1'b1, 32'h1100);
        push("alias_new", 1, 1, 32'h900, 0, 0, 0, 0, 0, 0, 0);
        next_cyc();
        drive_if(1'b0, 32'h1100);
        push("if_invalid", 1, 0, 32'h1104, 0, 0, 0, 0, 0, 0, 0);
        next_cyc();

        // Direction decode under hold: no mispredict, no stats movement
        foreach (dirs[i]) begin
            drive_ex(dirs[i].v, 1, dirs[i].t, 32'h40, dirs[i].z, dirs[i].lt,
                     dirs[i].ltu, 32'hA00, 1'b0, 32'h0);
            push(dirs[i].name, 0, 0, 0, 1, dirs[i].et, 0, 32'h44, 1, 32'd7, 32'd4);
            next_cyc();
        end

        // 6: held mispredicting bltu, then release
        drive_if(1'b1, 32'h308);
        for (int k = 0; k < 3; k++) begin
            drive_ex(1, 1, BR_BLTU, 32'h308, 0, 0, 1, 32'h50, 0, 32'h30C);
            push("bltu_hold", 1, 0, 32'h30C, 1, 1, 0, 32'h30C, 1, 32'd7, 32'd4);
            next_cyc();
        end
        drive_ex(1, 0, BR_BLTU, 32'h308, 0, 0, 1, 32'h50, 0, 32'h30C);
        push("bltu_rel", 1, 0, 32'h30C, 1, 1, 1, 32'h50, 1, 32'd7, 32'd4);
        next_cyc();
        ex_idle();
        push("bltu_after", 1, 1, 32'h50, 1, 0, 0, 32'h4, 1, 32'd8, 32'd5);
        next_cyc();

        // Asynchronous reset mid-cycle clears tables and stats at once
        drive_if(1'b1, 32'h1100);
        rst_n = 1'b0;
        push("async_rst", 1, 0, 32'h1104, 0, 0, 0, 0, 1, 32'd0, 32'd0);
        next_cyc();
        rst_n = 1'b1;
        drive_if(1'b1, 32'h204);
        push("post_rst", 1, 0, 32'h208, 0, 0, 0, 0, 1, 32'd0, 32'd0);
        next_cyc();

        // Drain with a bounded wait
        for (int w = 0; w < 10 && sb_q.size() > 0; w++)
            @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
